// File: rtl/cuckoo_t2_stage_if.sv
// Handshake/lookup bundle between the table-1 insert stage and the table-2 stage.
// master = table-1 side (drives keys, accepts evictions); slave = table-2 stage.
interface cuckoo_t2_stage_if #(
  parameter int KEY_W  = 32,
  parameter int KICK_W = 4
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are both
  // high; once raised, valid and its payload hold steady until that edge.
  logic              in_valid;
  logic [KEY_W-1:0]  in_key;
  logic [KICK_W-1:0] in_kick;
  logic              in_ready;

  logic              ev_valid;
  logic [KEY_W-1:0]  ev_key;
  logic [KICK_W-1:0] ev_kick;
  logic              ev_ready;

  logic              ins_done;
  logic              fail_o;
  logic [KEY_W-1:0]  drop_key;

  logic              lk_valid;
  logic [KEY_W-1:0]  lk_key;
  logic              lk_hit;

  modport master (
    output in_valid, in_key, in_kick, ev_ready, lk_valid, lk_key,
    input  in_ready, ev_valid, ev_key, ev_kick, ins_done, fail_o, drop_key, lk_hit
  );

  modport slave (
    input  in_valid, in_key, in_kick, ev_ready, lk_valid, lk_key,
    output in_ready, ev_valid, ev_key, ev_kick, ins_done, fail_o, drop_key, lk_hit
  );
endinterface

// File: rtl/cuckoo_t2_stage.sv
// Table-2 stage of the cuckoo insert path: places evicted keys at h2, displaces residents.
// Optional macro CUCKOO_T2_OCC_EN adds the occ filled-slot counter output.
module cuckoo_t2_stage #(
  parameter int KEY_W     = 32,
  parameter int IDX_W     = 4,
  parameter int KICK_W    = 4,
  parameter int MAX_KICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cuckoo_t2_stage_if.slave     bus,
  output logic [1:0]           dbg_state
`ifdef CUCKOO_T2_OCC_EN
  ,output logic [IDX_W:0]      occ
`endif
);

  localparam int SLOTS = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_EVICT = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] hash2(input logic [KEY_W-1:0] k);
    return k[IDX_W-1:0] ^ k[2*IDX_W-1:IDX_W];
  endfunction

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KICK_W-1:0] kick_q, kick_d;
  logic              in_ready_q, in_ready_d;
  logic              ev_valid_q, ev_valid_d;
  logic [KEY_W-1:0]  ev_key_q, ev_key_d;
  logic [KICK_W-1:0] ev_kick_q, ev_kick_d;
  logic              ins_done_q, ins_done_d;
  logic              fail_q, fail_d;
  logic [KEY_W-1:0]  drop_key_q, drop_key_d;
  logic              lk_hit_q, lk_hit_d;
  logic [SLOTS-1:0]  filled_q, filled_d;
  logic [KEY_W-1:0]  slot_key_q [SLOTS];
  logic [IDX_W:0]    occ_q, occ_d;

  logic              wr_en;
  logic [IDX_W-1:0]  probe_idx;
  logic [IDX_W-1:0]  lk_idx;
  logic [KICK_W:0]   kick_inc;
  logic              can_kick;
  logic              same_key;

  // One extra bit on the increment keeps an all-ones kick from wrapping to zero.
  assign kick_inc  = {1'b0, kick_q} + (KICK_W+1)'(1);
  assign can_kick  = int'(kick_inc) < MAX_KICKS;
  assign probe_idx = hash2(key_q);
  assign lk_idx    = hash2(bus.lk_key);
  assign same_key  = slot_key_q[probe_idx] == key_q;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    kick_d     = kick_q;
    in_ready_d = in_ready_q;
    ev_valid_d = ev_valid_q;
    ev_key_d   = ev_key_q;
    ev_kick_d  = ev_kick_q;
    ins_done_d = 1'b0;
    fail_d     = 1'b0;
    drop_key_d = drop_key_q;
    filled_d   = filled_q;
    wr_en      = 1'b0;
    occ_d      = occ_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          key_d      = bus.in_key;
          kick_d     = bus.in_kick;
          in_ready_d = 1'b0;
          state_d    = S_PROBE;
        end
      end
      S_PROBE: begin
        if (!filled_q[probe_idx]) begin
          wr_en               = 1'b1;
          filled_d[probe_idx] = 1'b1;
          ins_done_d          = 1'b1;
          in_ready_d          = 1'b1;
          state_d             = S_IDLE;
          if (occ_q < (IDX_W+1)'(SLOTS)) occ_d = occ_q + (IDX_W+1)'(1);
        end else if (same_key) begin
          ins_done_d = 1'b1;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end else if (can_kick) begin
          wr_en      = 1'b1;
          ev_valid_d = 1'b1;
          ev_key_d   = slot_key_q[probe_idx];
          ev_kick_d  = kick_inc[KICK_W-1:0];
          state_d    = S_EVICT;
        end else begin
          fail_d     = 1'b1;
          drop_key_d = key_q;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_EVICT: begin
        if (bus.ev_ready) begin
          ev_valid_d = 1'b0;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        ev_valid_d = 1'b0;
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Lookup reads the table before this cycle's write lands.
  assign lk_hit_d = bus.lk_valid && filled_q[lk_idx] && (slot_key_q[lk_idx] == bus.lk_key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      kick_q     <= '0;
      in_ready_q <= 1'b1;
      ev_valid_q <= 1'b0;
      ev_key_q   <= '0;
      ev_kick_q  <= '0;
      ins_done_q <= 1'b0;
      fail_q     <= 1'b0;
      drop_key_q <= '0;
      lk_hit_q   <= 1'b0;
      filled_q   <= '0;
      occ_q      <= '0;
      for (int i = 0; i < SLOTS; i++) slot_key_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      kick_q     <= kick_d;
      in_ready_q <= in_ready_d;
      ev_valid_q <= ev_valid_d;
      ev_key_q   <= ev_key_d;
      ev_kick_q  <= ev_kick_d;
      ins_done_q <= ins_done_d;
      fail_q     <= fail_d;
      drop_key_q <= drop_key_d;
      lk_hit_q   <= lk_hit_d;
      filled_q   <= filled_d;
      occ_q      <= occ_d;
      if (wr_en) slot_key_q[probe_idx] <= key_q;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_key   = ev_key_q;
  assign bus.ev_kick  = ev_kick_q;
  assign bus.ins_done = ins_done_q;
  assign bus.fail_o   = fail_q;
  assign bus.drop_key = drop_key_q;
  assign bus.lk_hit   = lk_hit_q;
  assign dbg_state    = state_q;

`ifdef CUCKOO_T2_OCC_EN
  assign occ = occ_q;
`else
  logic unused_occ;
  assign unused_occ = ^occ_q;
`endif

endmodule
